// File: rtl/cvxif_issue_buffer.sv
// Elastic FIFO between the issue stage and the CV-X-IF functional unit.
// Absorbs coprocessor back-pressure so the issue port never sees x_ready_i combinationally.

package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 4};
endpackage

package riscv;
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;
endpackage

package cvxif_issue_buffer_pkg;
  localparam int unsigned XLEN          = config_pkg::cva6_cfg_empty.XLEN;
  localparam int unsigned TRANS_ID_BITS = config_pkg::cva6_cfg_empty.TRANS_ID_BITS;

  typedef struct packed {
    logic [3:0]               fu;
    logic [7:0]               operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;
endpackage

module cvxif_issue_buffer #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
  parameter type                   fu_data_t = cvxif_issue_buffer_pkg::fu_data_t,
  parameter int unsigned           DEPTH     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     x_valid_i,
  output logic                     x_ready_o,
  input  fu_data_t                 fu_data_i,
  input  riscv::priv_lvl_t         priv_lvl_i,
  input  logic [31:0]              x_off_instr_i,
  output logic                     x_valid_o,
  input  logic                     x_ready_i,
  output fu_data_t                 fu_data_o,
  output riscv::priv_lvl_t         priv_lvl_o,
  output logic [31:0]              x_off_instr_o,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    fu_data_t         fu_data;
    riscv::priv_lvl_t priv_lvl;
    logic [31:0]      instr;
  } entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CVA6Cfg.XLEN == 0) begin : g_bad_cfg
    $error("cvxif_issue_buffer: DEPTH must be a power of two >= 2 and XLEN nonzero");
  end

  entry_t mem_q [DEPTH];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  logic   full, empty, push, pop;
  entry_t head;

  // Full/empty come from the count so equal pointers are never ambiguous.
  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  assign x_ready_o = ~full & ~flush_i;
  assign x_valid_o = ~empty & ~flush_i;
  assign push      = x_valid_i & x_ready_o;
  assign pop       = x_valid_o & x_ready_i;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{fu_data: fu_data_i, priv_lvl: priv_lvl_i, instr: x_off_instr_i};
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Payload is zeroed whenever the head is not presented.
  always_comb begin
    fu_data_o     = '0;
    priv_lvl_o    = riscv::priv_lvl_t'(2'b00);
    x_off_instr_o = '0;
    if (x_valid_o) begin
      fu_data_o     = head.fu_data;
      priv_lvl_o    = head.priv_lvl;
      x_off_instr_o = head.instr;
    end
  end

  assign usage_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule
